// File: rtl/dvp_cap_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dvp_cap_pkg
// Description : Shared types and helpers for the DVP to AXI4-Stream capture.
// Revision    : 1.0 - initial release
// ============================================================================
package dvp_cap_pkg;

  // Capture state: waiting for a frame start, capturing, or discarding a frame
  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    ACTIVE  = 2'd1,
    DROP    = 2'd2
  } cap_state_e;

  // Width of the pixel, line and frame counters
  localparam int CNT_W = 16;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_fwft
// Description : Single-clock first-word-fall-through FIFO. Head entry is
//               visible on rd_data whenever empty is low. A write while full
//               is accepted if a read happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             w_do_wr, w_do_rd;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign rd_data = mem_q[rd_ptr_q];
  assign w_do_rd = rd_en & ~empty;
  assign w_do_wr = wr_en & (~full | w_do_rd);

  // Pointer and occupancy update; pointers wrap naturally (DEPTH is 2^n)
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (w_do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({w_do_wr, w_do_rd})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers; storage cleared so the idle head reads zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (w_do_wr) mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dvp_axis_capture.sv
`default_nettype none
// ============================================================================
// Module      : dvp_axis_capture
// Description : DVP camera capture. Registers the camera bus, packs
//               BYTES_PER_PIX beats per pixel (first beat in the MSBs), and
//               emits an AXI4-Stream video stream (tuser = SOF, tlast = EOL)
//               through an output FIFO, with line/frame length checking and
//               whole-frame drop on FIFO overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module dvp_axis_capture
  import dvp_cap_pkg::*;
#(
  parameter int DATA_W        = 8,
  parameter int BYTES_PER_PIX = 2,
  parameter int H_ACTIVE      = 1280,
  parameter int V_ACTIVE      = 720,
  parameter int FIFO_DEPTH    = 16,
  parameter int VSYNC_POL     = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable,
  input  logic                            cam_vsync,
  input  logic                            cam_href,
  input  logic [DATA_W-1:0]               cam_data,
  output logic [DATA_W*BYTES_PER_PIX-1:0] m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tuser,
  output logic                            m_axis_tlast,
  output logic [15:0]                     frame_cnt,
  output logic                            line_err,
  output logic                            frame_err,
  output logic                            ovf_flag,
  input  logic                            ovf_clr
);
  localparam int               PIX_W     = DATA_W * BYTES_PER_PIX;
  localparam logic             VS_ACT    = (VSYNC_POL != 0);
  localparam logic [1:0]       BEAT_LAST = 2'(BYTES_PER_PIX - 1);
  localparam logic [CNT_W-1:0] H_EXP     = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_EXP     = CNT_W'(V_ACTIVE);

  // Stage S0 camera registers
  logic              vsync_s0_q, href_s0_q, href_prev_q;
  logic [DATA_W-1:0] data_s0_q;

  // Capture state
  cap_state_e       state_q, state_d;
  logic             seen_vs_q, seen_vs_d;
  logic [1:0]       beat_q, beat_d;
  logic [PIX_W-1:0] shift_q, shift_d;
  logic [PIX_W-1:0] hold_q, hold_d;
  logic             hold_vld_q, hold_vld_d;
  logic             sof_q, sof_d;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             line_err_q, line_err_d;
  logic             frame_err_q, frame_err_d;
  logic             ovf_q, ovf_d;

  logic             w_vs_act, w_active, w_beat, w_pix_done, w_line_end;
  logic             w_wr_req, w_wr_en, w_ovf, w_fifo_rd, w_fifo_full, w_fifo_empty;
  logic [PIX_W-1:0] w_shifted;
  logic [CNT_W-1:0] w_lines;

  assign w_vs_act   = (vsync_s0_q == VS_ACT);
  assign w_active   = (state_q == ACTIVE);
  // A line ends on href falling, or is cut short by vsync while href is high
  assign w_line_end = w_active & href_prev_q & (~href_s0_q | w_vs_act);
  assign w_beat     = w_active & href_s0_q & ~w_vs_act;
  assign w_pix_done = w_beat & (beat_q == BEAT_LAST);
  assign w_shifted  = (shift_q << DATA_W) | PIX_W'(data_s0_q);
  assign w_lines    = w_line_end ? sat_inc(line_cnt_q) : line_cnt_q;

  // The held pixel is released by the next completed pixel or by line end
  assign w_wr_req   = hold_vld_q & (w_pix_done | w_line_end);
  assign w_fifo_rd  = m_axis_tvalid & m_axis_tready;
  assign w_ovf      = w_wr_req & w_fifo_full & ~w_fifo_rd;
  assign w_wr_en    = w_wr_req & ~w_ovf;

  // Single register stage on the camera pins; previous href for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_s0_q  <= ~VS_ACT;
      href_s0_q   <= 1'b0;
      href_prev_q <= 1'b0;
      data_s0_q   <= '0;
    end else begin
      vsync_s0_q  <= cam_vsync;
      href_s0_q   <= cam_href;
      href_prev_q <= href_s0_q;
      data_s0_q   <= cam_data;
    end
  end

  // Next-state logic: frame sequencing, packing, holdback, length checks
  always_comb begin
    state_d     = state_q;
    seen_vs_d   = seen_vs_q;
    beat_d      = beat_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    sof_d       = sof_q;
    pix_cnt_d   = pix_cnt_q;
    line_cnt_d  = line_cnt_q;
    frame_cnt_d = frame_cnt_q;
    line_err_d  = 1'b0;
    frame_err_d = 1'b0;
    ovf_d       = w_ovf | (ovf_q & ~ovf_clr);

    case (state_q)
      WAIT_VS: begin
        beat_d     = '0;
        hold_vld_d = 1'b0;
        pix_cnt_d  = '0;
        line_cnt_d = '0;
        if (w_vs_act) begin
          seen_vs_d = 1'b1;
        end else if (seen_vs_q) begin
          // Trailing edge of vsync is the frame start; enable only matters here
          seen_vs_d = 1'b0;
          if (enable) begin
            state_d = ACTIVE;
            sof_d   = 1'b1;
          end
        end
      end

      ACTIVE: begin
        if (w_beat) begin
          shift_d = w_shifted;
          beat_d  = w_pix_done ? 2'd0 : beat_q + 2'd1;
        end
        if (w_pix_done) begin
          hold_d     = w_shifted;
          hold_vld_d = 1'b1;
          pix_cnt_d  = sat_inc(pix_cnt_q);
        end
        if (w_line_end) begin
          // Partial pixel is dropped; a vsync-cut line is always an error
          hold_vld_d = 1'b0;
          beat_d     = '0;
          pix_cnt_d  = '0;
          line_cnt_d = w_lines;
          line_err_d = (pix_cnt_q != H_EXP) | (beat_q != 2'd0) | href_s0_q;
        end
        if (w_wr_en) sof_d = 1'b0;
        if (w_ovf) begin
          state_d    = DROP;
          hold_vld_d = 1'b0;
        end else if (w_vs_act) begin
          state_d     = WAIT_VS;
          seen_vs_d   = 1'b1;
          frame_err_d = (w_lines != V_EXP);
          frame_cnt_d = frame_cnt_q + CNT_W'(1);
        end
      end

      DROP: begin
        beat_d     = '0;
        hold_vld_d = 1'b0;
        if (w_vs_act) begin
          state_d   = WAIT_VS;
          seen_vs_d = 1'b1;
        end
      end

      default: state_d = WAIT_VS;
    endcase
  end

  // Capture state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT_VS;
      seen_vs_q   <= 1'b0;
      beat_q      <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      sof_q       <= 1'b0;
      pix_cnt_q   <= '0;
      line_cnt_q  <= '0;
      frame_cnt_q <= '0;
      line_err_q  <= 1'b0;
      frame_err_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      seen_vs_q   <= seen_vs_d;
      beat_q      <= beat_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      sof_q       <= sof_d;
      pix_cnt_q   <= pix_cnt_d;
      line_cnt_q  <= line_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      line_err_q  <= line_err_d;
      frame_err_q <= frame_err_d;
      ovf_q       <= ovf_d;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (PIX_W + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (w_wr_en),
    .wr_data ({sof_q, w_line_end, hold_q}),
    .rd_en   (w_fifo_rd),
    .rd_data ({m_axis_tuser, m_axis_tlast, m_axis_tdata}),
    .full    (w_fifo_full),
    .empty   (w_fifo_empty)
  );

  assign m_axis_tvalid = ~w_fifo_empty;
  assign frame_cnt     = frame_cnt_q;
  assign line_err      = line_err_q;
  assign frame_err     = frame_err_q;
  assign ovf_flag      = ovf_q;

endmodule
`default_nettype wire
